// File: rtl/touch_pkg.sv
// Shared definitions for the touch-controller serial receive path.
// Header byte values, coordinate width and the two FSM state encodings.
// No logic; imported by uart_rx_byte and touch_uart_rx.
package touch_pkg;

  localparam logic [7:0] TOUCH_HDR_UP  = 8'h80;
  localparam logic [7:0] TOUCH_HDR_DN  = 8'h81;
  localparam int         TOUCH_COORD_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } bit_state_t;

  typedef enum logic [2:0] {
    HUNT,
    XL,
    XH,
    YL,
    YH
  } pkt_state_t;

  // A report header carries the pen state in bit 0; everything else with bit7 set is not a header.
  function automatic logic is_header(input logic [7:0] b);
    return (b == TOUCH_HDR_UP) || (b == TOUCH_HDR_DN);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, start-glitch rejection, mid-bit sampling.
// Latency: byte_stb / err_frame assert 1 cycle after the stop-bit sample (about 9.5 bit times after the start edge).
// Backpressure: none; byte_stb is a single-cycle strobe that the consumer must take when it fires.
module uart_rx_byte
  import touch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_stb,
  output logic [7:0] rx_byte,
  output logic       err_frame
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Two synchroniser cycles plus the edge-detect cycle already elapsed, so stop short of a full half bit
  // to land on the true centre of the start bit.
  localparam logic [CNT_W-1:0]  MID_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);

  logic             rxd_meta;
  logic             rxd_sync;
  logic             rxd_prev;
  bit_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Bring the asynchronous line into clk_clk domain and keep one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Bit-level FSM: find the start edge, confirm it at mid-bit, shift in 8 data bits LSB first, check the stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      byte_stb  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      err_frame <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == MID_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line already back high at mid-start is a glitch and is dropped silently.
            state   <= rxd_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxd_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rxd_sync) begin
              byte_stb <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              err_frame <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/touch_uart_rx.sv
// Touch controller receiver: deframes UART bytes and assembles 5-byte reports into pen events.
// Latency: evt_valid rises 2 cycles after the stop-bit sample of the last report byte.
// Backpressure: single-entry output held while evt_valid && !evt_ready; a report completing then is dropped with err_ovf.
// Optional build macro TOUCH_RX_STATS_EN adds saturating error counters cnt_frame / cnt_proto / cnt_ovf.
module touch_uart_rx
  import touch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic                     rxd,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TOUCH_COORD_W-1:0] evt_x,
  output logic [TOUCH_COORD_W-1:0] evt_y,
  output logic                     evt_pen,
  output logic                     err_frame,
  output logic                     err_proto,
  output logic                     err_ovf
`ifdef TOUCH_RX_STATS_EN
  ,
  output logic [15:0]              cnt_frame,
  output logic [15:0]              cnt_proto,
  output logic [15:0]              cnt_ovf
`endif
);

  localparam int LO_W = 7;
  localparam int HI_W = TOUCH_COORD_W - LO_W;

  logic            byte_stb;
  logic [7:0]      rx_byte;
  pkt_state_t      pkt_state;
  logic            pen_q;
  logic [LO_W-1:0] x_lo;
  logic [HI_W-1:0] x_hi;
  logic [LO_W-1:0] y_lo;
  logic            pkt_done;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .rxd      (rxd),
    .byte_stb (byte_stb),
    .rx_byte  (rx_byte),
    .err_frame(err_frame)
  );

  // The YH byte completes a report only if it is a data byte; a header there restarts instead.
  assign pkt_done = byte_stb && (pkt_state == YH) && !rx_byte[7];

  // Packet FSM: sync on a header, collect X/Y low/high 7+5 bit fields, abort on misplaced control bytes.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pkt_state <= HUNT;
      pen_q     <= 1'b0;
      x_lo      <= '0;
      x_hi      <= '0;
      y_lo      <= '0;
      err_proto <= 1'b0;
    end else begin
      err_proto <= 1'b0;
      if (err_frame) begin
        pkt_state <= HUNT;
      end else if (byte_stb) begin
        if ((pkt_state != HUNT) && rx_byte[7]) begin
          err_proto <= 1'b1;
          if (is_header(rx_byte)) begin
            pen_q     <= rx_byte[0];
            pkt_state <= XL;
          end else begin
            pkt_state <= HUNT;
          end
        end else begin
          unique case (pkt_state)
            HUNT: begin
              if (is_header(rx_byte)) begin
                pen_q     <= rx_byte[0];
                pkt_state <= XL;
              end
            end
            XL: begin
              x_lo      <= rx_byte[LO_W-1:0];
              pkt_state <= XH;
            end
            XH: begin
              x_hi      <= rx_byte[HI_W-1:0];
              pkt_state <= YL;
            end
            YL: begin
              y_lo      <= rx_byte[LO_W-1:0];
              pkt_state <= YH;
            end
            YH: pkt_state <= HUNT;
            default: pkt_state <= HUNT;
          endcase
        end
      end
    end
  end

  // Single-entry output register: load when empty or draining this cycle, otherwise drop and flag overflow.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      evt_valid <= 1'b0;
      evt_x     <= '0;
      evt_y     <= '0;
      evt_pen   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_ovf <= 1'b0;
      if (pkt_done) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_x     <= {x_hi, x_lo};
          evt_y     <= {rx_byte[HI_W-1:0], y_lo};
          evt_pen   <= pen_q;
        end else begin
          err_ovf <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

`ifdef TOUCH_RX_STATS_EN
  // Saturating error statistics for firmware polling.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt_frame <= '0;
      cnt_proto <= '0;
      cnt_ovf   <= '0;
    end else begin
      if (err_frame && (cnt_frame != 16'hFFFF)) cnt_frame <= cnt_frame + 16'd1;
      if (err_proto && (cnt_proto != 16'hFFFF)) cnt_proto <= cnt_proto + 16'd1;
      if (err_ovf   && (cnt_ovf   != 16'hFFFF)) cnt_ovf   <= cnt_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_touch_uart_rx.sv
// Bench for touch_uart_rx at CLKS_PER_BIT = 16: directed report scenarios plus randomized reports
// compared against events computed directly from the generated (pen, x, y) tuples.
module tb_touch_uart_rx;
  import touch_pkg::*;

  localparam int CPB = 16;

  typedef struct packed {
    logic        pen;
    logic [11:0] x;
    logic [11:0] y;
  } evt_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        rxd;
  logic        evt_valid;
  logic        evt_ready;
  logic [11:0] evt_x;
  logic [11:0] evt_y;
  logic        evt_pen;
  logic        err_frame;
  logic        err_proto;
  logic        err_ovf;

  logic rand_rdy = 1'b0;
  logic man_rdy  = 1'b1;
  logic rnd_rdy  = 1'b1;
  assign evt_ready = rand_rdy ? rnd_rdy : man_rdy;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_start_cyc = 0;
  int   rise_cyc = 0;
  int   n_frame = 0, n_proto = 0, n_ovf = 0, n_stb = 0;
  logic prev_valid = 1'b0;
  evt_t obs_q[$];

  touch_uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .rxd        (rxd),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_x      (evt_x),
    .evt_y      (evt_y),
    .evt_pen    (evt_pen),
    .err_frame  (err_frame),
    .err_proto  (err_proto),
    .err_ovf    (err_ovf)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) cyc <= cyc + 1;

  always @(posedge clk_clk) begin
    #2;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Observe on the falling edge: handshakes, error pulse cycles, internal byte strobes, valid rise time.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (evt_valid && evt_ready) obs_q.push_back({evt_pen, evt_x, evt_y});
      if (err_frame) n_frame++;
      if (err_proto) n_proto++;
      if (err_ovf) n_ovf++;
      if (dut.u_rx.byte_stb) n_stb++;
      if (evt_valid && !prev_valid) rise_cyc = cyc;
    end
    prev_valid = evt_valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    last_start_cyc = cyc;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
    tick(2);
  endtask

  // Report encoding: header carries pen, then X low 7, X high 5, Y low 7, Y high 5; bits [6:5] of high bytes are don't-care.
  task automatic send_pkt(input evt_t e);
    logic [1:0] j1, j2;
    j1 = 2'($urandom);
    j2 = 2'($urandom);
    send_byte(e.pen ? 8'h81 : 8'h80, 1'b1);
    send_byte({1'b0, e.x[6:0]}, 1'b1);
    send_byte({1'b0, j1, e.x[11:7]}, 1'b1);
    send_byte({1'b0, e.y[6:0]}, 1'b1);
    send_byte({1'b0, j2, e.y[11:7]}, 1'b1);
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    rxd = 1'b1;
    tick(3);
    n_chk++;
    if ({evt_valid, evt_pen, evt_x, evt_y, err_frame, err_proto, err_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b pen=%b x=%h y=%h errs=%b%b%b, required all 0",
               evt_valid, evt_pen, evt_x, evt_y, err_frame, err_proto, err_ovf);
    end
    reset_reset = 1'b0;
    tick(4);
  endtask

  task automatic test_basic();
    int b0, f0, p0, o0;
    evt_t exp;
    exp = {1'b1, 12'h805, 12'hFFF};
    b0 = obs_q.size(); f0 = n_frame; p0 = n_proto; o0 = n_ovf;
    man_rdy = 1'b1;
    send_byte(8'h81, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h1F, 1'b1);
    tick(4);
    n_chk++;
    if (obs_q.size() - b0 != 1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d events, required 1", obs_q.size() - b0);
    end else begin
      n_chk++;
      if (obs_q[b0] !== exp) begin
        n_fail++;
        $display("FAIL basic_event: got %h, required %h", obs_q[b0], exp);
      end
    end
    // Stop-bit centre of the last byte is 9.5 bits after its start edge, plus sync, strobe and load cycles.
    n_chk++;
    if ((rise_cyc - last_start_cyc) < 153 || (rise_cyc - last_start_cyc) > 157) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles from last start edge, required 153..157",
               rise_cyc - last_start_cyc);
    end
    n_chk++;
    if ((n_frame - f0) + (n_proto - p0) + (n_ovf - o0) != 0) begin
      n_fail++;
      $display("FAIL basic_errors: got %0d error pulses, required 0",
               (n_frame - f0) + (n_proto - p0) + (n_ovf - o0));
    end
  endtask

  task automatic test_frame_err();
    int b0, f0, p0;
    evt_t exp;
    exp = '0;
    b0 = obs_q.size(); f0 = n_frame; p0 = n_proto;
    send_byte(8'h81, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b0);
    send_byte(8'h80, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(4);
    n_chk++;
    if (n_frame - f0 != 1) begin
      n_fail++;
      $display("FAIL frame_pulses: got %0d err_frame cycles, required 1", n_frame - f0);
    end
    n_chk++;
    if (n_proto - p0 != 0) begin
      n_fail++;
      $display("FAIL frame_proto: got %0d err_proto cycles, required 0", n_proto - p0);
    end
    n_chk++;
    if (obs_q.size() - b0 != 1) begin
      n_fail++;
      $display("FAIL frame_count: got %0d events, required 1", obs_q.size() - b0);
    end else begin
      n_chk++;
      if (obs_q[b0] !== exp) begin
        n_fail++;
        $display("FAIL frame_event: got %h, required %h", obs_q[b0], exp);
      end
    end
  endtask

  task automatic test_proto();
    int b0, p0;
    evt_t exp;
    exp = {1'b0, 12'h001, 12'h002};
    b0 = obs_q.size(); p0 = n_proto;
    send_byte(8'h81, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(4);
    n_chk++;
    if (n_proto - p0 != 1) begin
      n_fail++;
      $display("FAIL proto_pulses: got %0d err_proto cycles, required 1", n_proto - p0);
    end
    n_chk++;
    if (obs_q.size() - b0 != 1) begin
      n_fail++;
      $display("FAIL proto_count: got %0d events, required 1", obs_q.size() - b0);
    end else begin
      n_chk++;
      if (obs_q[b0] !== exp) begin
        n_fail++;
        $display("FAIL proto_event: got %h, required %h", obs_q[b0], exp);
      end
    end
  endtask

  task automatic test_overflow();
    int b0, o0;
    evt_t ea, eb;
    ea = {1'b1, 12'h123, 12'h456};
    eb = {1'b0, 12'hABC, 12'h0DE};
    b0 = obs_q.size(); o0 = n_ovf;
    man_rdy = 1'b0;
    send_pkt(ea);
    tick(4);
    n_chk++;
    if ({evt_valid, evt_pen, evt_x, evt_y} !== {1'b1, ea}) begin
      n_fail++;
      $display("FAIL ovf_first_held: got valid=%b evt=%h, required valid=1 evt=%h",
               evt_valid, {evt_pen, evt_x, evt_y}, ea);
    end
    send_pkt(eb);
    tick(4);
    n_chk++;
    if ({evt_valid, evt_pen, evt_x, evt_y} !== {1'b1, ea}) begin
      n_fail++;
      $display("FAIL ovf_still_held: got valid=%b evt=%h, required valid=1 evt=%h",
               evt_valid, {evt_pen, evt_x, evt_y}, ea);
    end
    n_chk++;
    if (n_ovf - o0 != 1) begin
      n_fail++;
      $display("FAIL ovf_pulses: got %0d err_ovf cycles, required 1", n_ovf - o0);
    end
    man_rdy = 1'b1;
    tick(4);
    n_chk++;
    if (obs_q.size() - b0 != 1) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d events, required 1", obs_q.size() - b0);
    end else begin
      n_chk++;
      if (obs_q[b0] !== ea) begin
        n_fail++;
        $display("FAIL ovf_event: got %h, required %h", obs_q[b0], ea);
      end
    end
    n_chk++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drained: got valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_glitch();
    int s0, e0, b0;
    evt_t exp;
    exp = {1'b1, 12'h7A5, 12'h35C};
    s0 = n_stb; e0 = n_frame + n_proto + n_ovf;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(3 * CPB);
    n_chk++;
    if (n_stb - s0 != 0) begin
      n_fail++;
      $display("FAIL glitch_stb: got %0d byte strobes, required 0", n_stb - s0);
    end
    n_chk++;
    if (n_frame + n_proto + n_ovf - e0 != 0) begin
      n_fail++;
      $display("FAIL glitch_errors: got %0d error pulses, required 0", n_frame + n_proto + n_ovf - e0);
    end
    n_chk++;
    if (dut.u_rx.state !== IDLE) begin
      n_fail++;
      $display("FAIL glitch_state: got %0d, required IDLE", dut.u_rx.state);
    end
    b0 = obs_q.size();
    send_pkt(exp);
    tick(4);
    n_chk++;
    if (obs_q.size() - b0 != 1) begin
      n_fail++;
      $display("FAIL glitch_recover_count: got %0d events, required 1", obs_q.size() - b0);
    end else begin
      n_chk++;
      if (obs_q[b0] !== exp) begin
        n_fail++;
        $display("FAIL glitch_recover_event: got %h, required %h", obs_q[b0], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b0, p0;
    evt_t ec, ee;
    ec = {1'b1, 12'hFED, 12'h012};
    ee = {1'b0, 12'h3C3, 12'hC3C};
    man_rdy = 1'b0;
    send_pkt(ec);
    send_byte(8'h81, 1'b1);
    send_byte(8'h55, 1'b1);
    reset_reset = 1'b1;
    tick(2);
    n_chk++;
    if ({evt_valid, evt_pen, evt_x, evt_y, err_frame, err_proto, err_ovf} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%b pen=%b x=%h y=%h errs=%b%b%b, required all 0",
               evt_valid, evt_pen, evt_x, evt_y, err_frame, err_proto, err_ovf);
    end
    reset_reset = 1'b0;
    man_rdy = 1'b1;
    tick(3);
    b0 = obs_q.size(); p0 = n_proto;
    send_pkt(ee);
    tick(4);
    n_chk++;
    if (n_proto - p0 != 0) begin
      n_fail++;
      $display("FAIL midreset_proto: got %0d err_proto cycles, required 0", n_proto - p0);
    end
    n_chk++;
    if (obs_q.size() - b0 != 1) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d events, required 1", obs_q.size() - b0);
    end else begin
      n_chk++;
      if (obs_q[b0] !== ee) begin
        n_fail++;
        $display("FAIL midreset_event: got %h, required %h", obs_q[b0], ee);
      end
    end
  endtask

  task automatic test_random();
    int   b0, e0;
    evt_t exp_q[$];
    evt_t e;
    logic [7:0] junk;
    b0 = obs_q.size(); e0 = n_frame + n_proto + n_ovf;
    rand_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        junk = 8'($urandom);
        if (junk == 8'h80 || junk == 8'h81) junk = 8'h7E;
        send_byte(junk, 1'b1);
      end
      e.pen = 1'($urandom);
      e.x   = 12'($urandom);
      e.y   = 12'($urandom);
      exp_q.push_back(e);
      send_pkt(e);
    end
    tick(20);
    rand_rdy = 1'b0;
    man_rdy  = 1'b1;
    tick(5);
    n_chk++;
    if (obs_q.size() - b0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d events, required %0d", obs_q.size() - b0, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_chk++;
        if (obs_q[b0 + k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random_event[%0d]: got %h, required %h", k, obs_q[b0 + k], exp_q[k]);
        end
      end
    end
    n_chk++;
    if (n_frame + n_proto + n_ovf - e0 != 0) begin
      n_fail++;
      $display("FAIL random_errors: got %0d error pulses, required 0", n_frame + n_proto + n_ovf - e0);
    end
  endtask

  initial begin
    reset_reset = 1'b1;
    rxd = 1'b1;
    test_reset();
    test_basic();
    test_frame_err();
    test_proto();
    test_overflow();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
